// File: rtl/cb_pkg.sv
// Shared types for the CB-prefix bit-op sequencer: FSM states, opcode groups, rotate sub-ops.
// Flag positions follow the {Z,N,H,C} packing used by the flag register.
package cb_pkg;

    typedef enum logic [1:0] {IDLE, P1, P2, DONE} state_e;

    typedef enum logic [1:0] {
        ROT = 2'b00,
        BIT = 2'b01,
        RES = 2'b10,
        SET = 2'b11
    } group_e;

    typedef enum logic [2:0] {RLC, RRC, RL, RR, SLA, SRA, SWAP, SRL} rot_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    // Right shifts walk the byte high nibble first so the carry flows downward.
    function automatic logic rot_is_right(input rot_e op);
        return op inside {RRC, RR, SRA, SRL};
    endfunction

endpackage

// File: rtl/cb_nibble_slice.sv
// Combinational 4-bit bit-op slice, time-shared by the sequencer across both nibble passes.
// Zero latency; no flow control.
module cb_nibble_slice
    import cb_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       cin_i,
    input  group_e     grp_i,
    input  rot_e       sub_i,
    input  logic [2:0] idx_i,
    input  logic       hi_i,
    input  logic       dir_right_i,
    output logic [3:0] nib_o,
    output logic       cout_o
);

    logic       sel;
    logic [3:0] mask;

    always_comb begin
        sel    = (idx_i[2] == hi_i);
        mask   = 4'b0001 << idx_i[1:0];
        nib_o  = nib_i;
        cout_o = cin_i;
        case (grp_i)
            ROT: begin
                if (sub_i == SWAP) begin
                    nib_o  = nib_i;
                    cout_o = 1'b0;
                end else if (dir_right_i) begin
                    nib_o  = {cin_i, nib_i[3:1]};
                    cout_o = nib_i[0];
                end else begin
                    nib_o  = {nib_i[2:0], cin_i};
                    cout_o = nib_i[3];
                end
            end
            // BIT isolates the tested bit so the sequencer's zero accumulation yields Z.
            BIT: nib_o = sel ? (nib_i & mask) : 4'h0;
            RES: if (sel) nib_o = nib_i & ~mask;
            SET: if (sel) nib_o = nib_i | mask;
        endcase
    end

endmodule

// File: rtl/cb_bitop_seq.sv
// CB-opcode sequencer: one byte as two nibble passes; done 3 cycles after accept, ready only in IDLE.
// With CB_FAST_BIT_EN defined, BIT uses a single pass on the nibble holding idx (done 2 cycles after accept).
module cb_bitop_seq
    import cb_pkg::*;
(
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    output logic       ready,
    input  logic [7:0] opcode,
    input  logic [7:0] din,
    input  logic [3:0] flags_in,
    output logic [7:0] dout,
    output logic [3:0] flags_out,
    output logic       done,
    output logic       dout_we,
    output logic       flags_we
);

    state_e     state_q, state_d;
    logic [4:0] op_q;
    logic [7:0] din_q, res_q, dout_q;
    logic [3:0] fin_q, fout_q;
    logic       carry_q, z_q;

    group_e     grp;
    rot_e       sub;
    logic [2:0] idx;
    logic       dir_right, fast_bit, first_hi, cur_hi, dst_hi;
    logic       first_cin, cin, final_pass, nib_zero, z_final;
    logic [3:0] slice_nib, slice_out;
    logic       slice_cout;
    logic [7:0] wr_byte, res_byte;
    logic [3:0] flags_new;
    logic       unused_opc;

    assign unused_opc = ^opcode[2:0];

    assign grp       = group_e'(op_q[4:3]);
    assign sub       = rot_e'(op_q[2:0]);
    assign idx       = op_q[2:0];
    assign dir_right = (grp == ROT) && rot_is_right(sub);

`ifdef CB_FAST_BIT_EN
    assign fast_bit = (grp == BIT);
    assign first_hi = fast_bit ? idx[2] : dir_right;
`else
    assign fast_bit = 1'b0;
    assign first_hi = dir_right;
`endif

    assign cur_hi    = (state_q == P2) ? ~first_hi : first_hi;
    assign slice_nib = cur_hi ? din_q[7:4] : din_q[3:0];

    // Byte-level wrap/fill enters on the first pass; the second pass takes the inter-nibble carry.
    always_comb begin
        first_cin = 1'b0;
        if (grp == ROT) begin
            case (sub)
                RLC:     first_cin = din_q[7];
                RRC:     first_cin = din_q[0];
                RL, RR:  first_cin = fin_q[FLAG_C];
                SRA:     first_cin = din_q[7];
                default: first_cin = 1'b0;
            endcase
        end else begin
            first_cin = fin_q[FLAG_C];
        end
    end

    assign cin = (state_q == P1) ? first_cin : carry_q;

    cb_nibble_slice u_slice (
        .nib_i       (slice_nib),
        .cin_i       (cin),
        .grp_i       (grp),
        .sub_i       (sub),
        .idx_i       (idx),
        .hi_i        (cur_hi),
        .dir_right_i (dir_right),
        .nib_o       (slice_out),
        .cout_o      (slice_cout)
    );

    assign dst_hi     = ((grp == ROT) && (sub == SWAP)) ? ~cur_hi : cur_hi;
    assign wr_byte    = dst_hi ? {slice_out, res_q[3:0]} : {res_q[7:4], slice_out};
    assign nib_zero   = (slice_out == 4'h0);
    assign z_final    = (state_q == P2) ? (z_q & nib_zero) : nib_zero;
    assign final_pass = (state_q == P2) || ((state_q == P1) && fast_bit);
    assign res_byte   = (grp == BIT) ? din_q : wr_byte;

    always_comb begin
        flags_new = fin_q;
        case (grp)
            ROT: begin
                flags_new         = 4'h0;
                flags_new[FLAG_Z] = z_final;
                flags_new[FLAG_C] = slice_cout;
            end
            BIT: begin
                flags_new         = 4'h0;
                flags_new[FLAG_Z] = z_final;
                flags_new[FLAG_H] = 1'b1;
                flags_new[FLAG_C] = fin_q[FLAG_C];
            end
            default: flags_new = fin_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = P1;
            P1:      state_d = fast_bit ? DONE : P2;
            P2:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= IDLE;
            op_q    <= 5'h00;
            din_q   <= 8'h00;
            fin_q   <= 4'h0;
            res_q   <= 8'h00;
            carry_q <= 1'b0;
            z_q     <= 1'b0;
            dout_q  <= 8'h00;
            fout_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && start) begin
                op_q  <= opcode[7:3];
                din_q <= din;
                fin_q <= flags_in;
            end
            if (state_q == P1) begin
                res_q   <= wr_byte;
                carry_q <= slice_cout;
                z_q     <= nib_zero;
            end
            if (final_pass) begin
                dout_q <= res_byte;
                fout_q <= flags_new;
            end
        end
    end

    assign ready     = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign dout_we   = done && (grp != BIT);
    assign flags_we  = done && ((grp == ROT) || (grp == BIT));
    assign dout      = dout_q;
    assign flags_out = fout_q;

endmodule

// File: tb/tb_cb_bitop_seq.sv
// Directed bench for cb_bitop_seq: vector table plus hand-built reset, busy-start and hold sequences.
module tb_cb_bitop_seq;

    logic       clk = 1'b0;
    logic       nreset, start;
    logic       ready, done, dout_we, flags_we;
    logic [7:0] opcode, din, dout;
    logic [3:0] flags_in, flags_out;

    int n_chk  = 0;
    int n_fail = 0;

    cb_bitop_seq dut (
        .clk       (clk),
        .nreset    (nreset),
        .start     (start),
        .ready     (ready),
        .opcode    (opcode),
        .din       (din),
        .flags_in  (flags_in),
        .dout      (dout),
        .flags_out (flags_out),
        .done      (done),
        .dout_we   (dout_we),
        .flags_we  (flags_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] op;
        logic [7:0] d;
        logic [3:0] f;
        logic [7:0] ed;
        logic [3:0] ef;
        logic       edwe;
        logic       efwe;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] op);
`ifdef CB_FAST_BIT_EN
        return (op[7:6] == 2'b01) ? 2 : 3;
`else
        return 3;
`endif
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        chk(tag, "ready_before", 32'(ready), 32'd1);
        chk(tag, "done_before", 32'(done), 32'd0);
        opcode   = v.op;
        din      = v.d;
        flags_in = v.f;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        din      = ~v.d;
        flags_in = ~v.f;
        lat      = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            if (done === 1'b1) lat = k;
            else @(negedge clk);
        end
        chk(tag, "latency", 32'(lat), 32'(exp_lat(v.op)));
        if (lat != 0) begin
            chk(tag, "dout", 32'(dout), 32'(v.ed));
            chk(tag, "flags", 32'(flags_out), 32'(v.ef));
            chk(tag, "dout_we", 32'(dout_we), 32'(v.edwe));
            chk(tag, "flags_we", 32'(flags_we), 32'(v.efwe));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;

        //          op     din    fin    dout   flags  dwe   fwe
        vecs[0]  = '{8'h98, 8'hFF, 4'hA, 8'hF7, 4'hA, 1'b1, 1'b0}; // RES 3
        vecs[1]  = '{8'hB8, 8'hA5, 4'h5, 8'h25, 4'h5, 1'b1, 1'b0}; // RES 7
        vecs[2]  = '{8'h80, 8'h00, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0}; // RES 0
        vecs[3]  = '{8'h40, 8'h00, 4'h1, 8'h00, 4'hB, 1'b0, 1'b1}; // BIT 0
        vecs[4]  = '{8'h78, 8'h80, 4'h0, 8'h80, 4'h2, 1'b0, 1'b1}; // BIT 7
        vecs[5]  = '{8'h00, 8'h85, 4'h0, 8'h0B, 4'h1, 1'b1, 1'b1}; // RLC
        vecs[6]  = '{8'h18, 8'h01, 4'h0, 8'h00, 4'h9, 1'b1, 1'b1}; // RR
        vecs[7]  = '{8'h30, 8'hA5, 4'h1, 8'h5A, 4'h0, 1'b1, 1'b1}; // SWAP
        vecs[8]  = '{8'h28, 8'h81, 4'h0, 8'hC0, 4'h1, 1'b1, 1'b1}; // SRA
        vecs[9]  = '{8'hE8, 8'h00, 4'h6, 8'h20, 4'h6, 1'b1, 1'b0}; // SET 5
        vecs[10] = '{8'h10, 8'h80, 4'h1, 8'h01, 4'h1, 1'b1, 1'b1}; // RL with C=1
        vecs[11] = '{8'h38, 8'h10, 4'h0, 8'h08, 4'h0, 1'b1, 1'b1}; // SRL
        vecs[12] = '{8'h20, 8'h08, 4'h0, 8'h10, 4'h0, 1'b1, 1'b1}; // SLA
        vecs[13] = '{8'h08, 8'h01, 4'h0, 8'h80, 4'h1, 1'b1, 1'b1}; // RRC
        vecs[14] = '{8'h60, 8'h10, 4'hE, 8'h10, 4'h2, 1'b0, 1'b1}; // BIT 4

        nreset   = 1'b0;
        start    = 1'b0;
        opcode   = 8'h00;
        din      = 8'h00;
        flags_in = 4'h0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        chk("reset", "ready", 32'(ready), 32'd1);
        chk("reset", "done", 32'(done), 32'd0);
        chk("reset", "dout_we", 32'(dout_we), 32'd0);
        chk("reset", "flags_we", 32'(flags_we), 32'd0);
        chk("reset", "dout", 32'(dout), 32'h00);
        chk("reset", "flags", 32'(flags_out), 32'h0);

        // Consecutive table entries are accepted at T+4 of the previous one.
        for (int i = 0; i < 15; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // start asserted during P1/P2 must be neither accepted nor queued.
        @(negedge clk);
        opcode = 8'h30; din = 8'hA5; flags_in = 4'h1; start = 1'b1;
        @(negedge clk);
        chk("busy", "ready_t1", 32'(ready), 32'd0);
        opcode = 8'hE8; din = 8'h00; flags_in = 4'h6;
        @(negedge clk);
        chk("busy", "ready_t2", 32'(ready), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("busy", "ready_t3", 32'(ready), 32'd0);
        chk("busy", "done_t3", 32'(done), 32'd1);
        chk("busy", "dout_t3", 32'(dout), 32'h5A);
        dcount = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) chk("busy", "ready_t4", 32'(ready), 32'd1);
            if (done === 1'b1) dcount++;
        end
        chk("busy", "done_count", 32'(dcount), 32'd1);
        chk("hold", "dout", 32'(dout), 32'h5A);
        chk("hold", "flags", 32'(flags_out), 32'h0);

        // Reset asserted in P2 aborts the operation with no completion.
        @(negedge clk);
        opcode = 8'h00; din = 8'h85; flags_in = 4'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        chk("abort", "done", 32'(done), 32'd0);
        chk("abort", "ready", 32'(ready), 32'd1);
        chk("abort", "dout", 32'(dout), 32'h00);
        chk("abort", "flags", 32'(flags_out), 32'h0);
        chk("abort", "dout_we", 32'(dout_we), 32'd0);
        chk("abort", "flags_we", 32'(flags_we), 32'd0);
        nreset = 1'b1;
        dcount = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        chk("abort", "late_done", 32'(dcount), 32'd0);

        // Back-to-back service after the abort.
        run_op(vecs[5], "b2b_rlc");
        run_op(vecs[3], "b2b_bit0");
        run_op(vecs[8], "b2b_sra");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
